// File: rtl/aquisicao_pressao_ventilacao.sv
// Pressure acquisition front-end for the ventilation controller.
// Sweeps seven pressure channels through one shared 4-bit converter and keeps a
// registered pressure word per channel. A converter that does not answer within
// 16 wait cycles yields the fail-safe value 4'b0000 and sets a sticky fault flag.
// Optional build macro: FILTRO_MEDIA_EN enables rounded two-sample averaging per channel.
module aquisicao_pressao_ventilacao (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] adcDado,
    input  logic       adcPronto,
    output logic       adcReq,
    output logic [2:0] adcCanal,
    output logic [3:0] sensPresSC,
    output logic [3:0] sensPresS1,
    output logic [3:0] sensPresS2,
    output logic [3:0] sensPresS3,
    output logic [3:0] sensPresTubSR,
    output logic [3:0] sensPresTubSS,
    output logic [3:0] sensPresRea,
    output logic       dadosValidos,
    output logic       falhaAdc,
    output logic       varreduraCompleta
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        SOLICITA = 2'd1,
        ESPERA   = 2'd2,
        GRAVA    = 2'd3
    } estado_t;

    localparam logic [2:0] ULTIMO_CANAL = 3'd6;
    localparam logic [3:0] CONT_LIMITE  = 4'd15;
    localparam logic [3:0] FAIL_SAFE    = 4'b0000;

    estado_t    estado_q, estado_d;
    logic [2:0] canal_q, canal_d;
    logic [3:0] cont_q, cont_d;
    logic [3:0] amostra_q, amostra_d;
    logic [3:0] pres_q [0:6];
    logic [3:0] pres_d [0:6];
    logic       valido_q, valido_d;
    logic       falha_q, falha_d;
    logic       varre_q, varre_d;
    logic       req_q, req_d;
    logic [3:0] novo_s;

`ifdef FILTRO_MEDIA_EN
    logic [6:0] primeiro_q, primeiro_d;
    logic       amostra_to_q, amostra_to_d;

    // Rounded mean of two 4-bit words; the 5-bit sum cannot overflow.
    function automatic logic [3:0] media(input logic [3:0] antigo, input logic [3:0] novo);
        logic [4:0] soma;
        soma  = {1'b0, antigo} + {1'b0, novo} + 5'd1;
        media = soma[4:1];
    endfunction
`endif

    // Next-state, capture and channel-update logic of the acquisition sequencer.
    always_comb begin
        estado_d  = estado_q;
        canal_d   = canal_q;
        cont_d    = cont_q;
        amostra_d = amostra_q;
        pres_d    = pres_q;
        valido_d  = valido_q;
        falha_d   = falha_q;
        varre_d   = 1'b0;
        novo_s    = FAIL_SAFE;
`ifdef FILTRO_MEDIA_EN
        primeiro_d   = primeiro_q;
        amostra_to_d = amostra_to_q;
`endif
        case (estado_q)
            OCIOSO: begin
                estado_d = SOLICITA;
            end
            SOLICITA: begin
                cont_d   = 4'd0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                cont_d = cont_q + 4'd1;
                // A real answer wins over a simultaneous timeout.
                if (adcPronto) begin
                    amostra_d = adcDado;
`ifdef FILTRO_MEDIA_EN
                    amostra_to_d = 1'b0;
`endif
                    estado_d  = GRAVA;
                end else if (cont_q == CONT_LIMITE) begin
                    amostra_d = FAIL_SAFE;
`ifdef FILTRO_MEDIA_EN
                    amostra_to_d = 1'b1;
`endif
                    falha_d   = 1'b1;
                    estado_d  = GRAVA;
                end else begin
                    estado_d = ESPERA;
                end
            end
            GRAVA: begin
`ifdef FILTRO_MEDIA_EN
                novo_s = amostra_q;
                for (int i = 0; i < 7; i++) begin
                    if ((canal_q == 3'(i)) && !amostra_to_q && !primeiro_q[i]) begin
                        novo_s = media(pres_q[i], amostra_q);
                    end else begin
                        novo_s = novo_s;
                    end
                end
`else
                novo_s = amostra_q;
`endif
                for (int i = 0; i < 7; i++) begin
                    if (canal_q == 3'(i)) begin
                        pres_d[i] = novo_s;
`ifdef FILTRO_MEDIA_EN
                        primeiro_d[i] = 1'b0;
`endif
                    end else begin
                        pres_d[i] = pres_q[i];
                    end
                end
                if (canal_q == ULTIMO_CANAL) begin
                    canal_d  = 3'd0;
                    varre_d  = 1'b1;
                    valido_d = 1'b1;
                end else begin
                    canal_d = canal_q + 3'd1;
                end
                estado_d = SOLICITA;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        req_d = (estado_d == SOLICITA) || (estado_d == ESPERA);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            canal_q   <= 3'd0;
            cont_q    <= 4'd0;
            amostra_q <= 4'd0;
            for (int i = 0; i < 7; i++) begin
                pres_q[i] <= 4'd0;
            end
            valido_q  <= 1'b0;
            falha_q   <= 1'b0;
            varre_q   <= 1'b0;
            req_q     <= 1'b0;
`ifdef FILTRO_MEDIA_EN
            primeiro_q   <= 7'b1111111;
            amostra_to_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            canal_q   <= canal_d;
            cont_q    <= cont_d;
            amostra_q <= amostra_d;
            pres_q    <= pres_d;
            valido_q  <= valido_d;
            falha_q   <= falha_d;
            varre_q   <= varre_d;
            req_q     <= req_d;
`ifdef FILTRO_MEDIA_EN
            primeiro_q   <= primeiro_d;
            amostra_to_q <= amostra_to_d;
`endif
        end
    end

    assign adcReq            = req_q;
    assign adcCanal          = canal_q;
    assign sensPresSC        = pres_q[0];
    assign sensPresS1        = pres_q[1];
    assign sensPresS2        = pres_q[2];
    assign sensPresS3        = pres_q[3];
    assign sensPresTubSR     = pres_q[4];
    assign sensPresTubSS     = pres_q[5];
    assign sensPresRea       = pres_q[6];
    assign dadosValidos      = valido_q;
    assign falhaAdc          = falha_q;
    assign varreduraCompleta = varre_q;

endmodule

// File: tb/tb_aquisicao_pressao_ventilacao.sv
// Self-checking bench for aquisicao_pressao_ventilacao. A conversion-level model
// (request cycle, up to 16 wait cycles, one write cycle) predicts every output on
// every cycle; directed scenarios pin the model with hand-computed values.
module tb_aquisicao_pressao_ventilacao;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] adcDado = 4'd0;
    logic       adcPronto = 1'b0;
    logic       adcReq;
    logic [2:0] adcCanal;
    logic [3:0] p0, p1, p2, p3, p4, p5, p6;
    logic       dadosValidos, falhaAdc, varreduraCompleta;

    aquisicao_pressao_ventilacao dut (
        .clk(clk), .rst_n(rst_n), .adcDado(adcDado), .adcPronto(adcPronto),
        .adcReq(adcReq), .adcCanal(adcCanal),
        .sensPresSC(p0), .sensPresS1(p1), .sensPresS2(p2), .sensPresS3(p3),
        .sensPresTubSR(p4), .sensPresTubSS(p5), .sensPresRea(p6),
        .dadosValidos(dadosValidos), .falhaAdc(falhaAdc),
        .varreduraCompleta(varreduraCompleta)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_age 0 = request cycle, 1..16 = wait cycle n, 17 = write cycle.
    bit m_idle = 1'b1;
    int m_age = 0;
    int m_ch = 0;
    int m_pres [7] = '{0, 0, 0, 0, 0, 0, 0};
    bit m_first [7] = '{1, 1, 1, 1, 1, 1, 1};
    int m_cap = 0;
    bit m_to = 1'b0;
    bit m_dv = 1'b0;
    bit m_falha = 1'b0;
    bit m_vc = 1'b0;

    // Stimulus configuration: wait_cfg 0 = random, 1..16 answer on that wait cycle, 17 = silent.
    int wait_cfg [7];
    int data_cfg [7];
    bit noise = 1'b0;
    int cur_tgt = 1;
    int req4_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_idle = 1'b1; m_age = 0; m_ch = 0; m_dv = 1'b0; m_falha = 1'b0; m_vc = 1'b0;
            m_cap = 0; m_to = 1'b0;
            for (int i = 0; i < 7; i++) begin m_pres[i] = 0; m_first[i] = 1'b1; end
        end else begin
            m_vc = 1'b0;
            if (m_idle) begin
                m_idle = 1'b0; m_age = 0;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_age <= 16) begin
                if (adcPronto) begin
                    m_cap = int'(adcDado); m_to = 1'b0; m_age = 17;
                end else if (m_age == 16) begin
                    m_cap = 0; m_to = 1'b1; m_falha = 1'b1; m_age = 17;
                end else begin
                    m_age++;
                end
            end else begin
`ifdef FILTRO_MEDIA_EN
                if (m_to || m_first[m_ch]) m_pres[m_ch] = m_cap;
                else m_pres[m_ch] = (m_pres[m_ch] + m_cap + 1) / 2;
`else
                m_pres[m_ch] = m_cap;
`endif
                m_first[m_ch] = 1'b0;
                if (m_ch == 6) begin m_vc = 1'b1; m_dv = 1'b1; end
                m_ch = (m_ch + 1) % 7;
                m_age = 0;
            end
        end
    endtask

    // One clock: update model on the edge, compare on the falling edge, then drive inputs.
    task automatic step();
        int got [7];
        @(posedge clk);
        model_edge();
        @(negedge clk);
        got = '{int'(p0), int'(p1), int'(p2), int'(p3), int'(p4), int'(p5), int'(p6)};
        chk("adcReq", int'(adcReq), int'(!m_idle && m_age <= 16));
        chk("adcCanal", int'(adcCanal), m_ch);
        for (int i = 0; i < 7; i++) chk($sformatf("sensPres[%0d]", i), got[i], m_pres[i]);
        chk("dadosValidos", int'(dadosValidos), int'(m_dv));
        chk("falhaAdc", int'(falhaAdc), int'(m_falha));
        chk("varreduraCompleta", int'(varreduraCompleta), int'(m_vc));
        if (adcReq && adcCanal == 3'd4) req4_cnt++;
        #1;
        adcDado = 4'($urandom_range(0, 15));
        adcPronto = 1'b0;
        if (!m_idle && m_age >= 1 && m_age <= 16) begin
            if (m_age == cur_tgt) begin
                adcPronto = 1'b1;
                adcDado = (data_cfg[m_ch] < 0) ? 4'($urandom_range(0, 15)) : 4'(data_cfg[m_ch]);
            end
        end else begin
            if (noise) adcPronto = 1'($urandom_range(0, 1));
            if (!m_idle && m_age == 0) begin
                if (wait_cfg[m_ch] == 0)
                    cur_tgt = ($urandom_range(0, 19) == 0) ? 17 : int'($urandom_range(1, 16));
                else
                    cur_tgt = wait_cfg[m_ch];
            end
        end
    endtask

    task automatic sweep(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!varreduraCompleta && cyc < 400);
        chk("sweep_bound", int'(varreduraCompleta), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int exp_rea;
        for (int i = 0; i < 7; i++) begin wait_cfg[i] = 1; data_cfg[i] = i + 8; end
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_req", int'(adcReq), 0);
        chk("reset_rea", int'(p6), 0);
        chk("reset_valid", int'(dadosValidos), 0);
        rst_n = 1'b1;

        // Immediate answers, data = channel+8.
        sweep(cyc);
        chk("sweep_cycles", cyc, 22);
        chk("sc_val", int'(p0), 8);
        chk("s3_val", int'(p3), 11);
        chk("rea_val", int'(p6), 14);
        chk("valid_first", int'(dadosValidos), 1);
        chk("falha_clean", int'(falhaAdc), 0);

        // Channel 4 silent, then good sweeps.
        wait_cfg[4] = 17;
        req4_cnt = 0;
        sweep(cyc);
        chk("req4_cycles", req4_cnt, 17);
        chk("tubsr_failsafe", int'(p4), 0);
        chk("falha_set", int'(falhaAdc), 1);
        wait_cfg[4] = 0;
        repeat (2) sweep(cyc);
        chk("falha_sticky", int'(falhaAdc), 1);

        // Answer on the timeout cycle of channel 2.
        do_reset();
        wait_cfg[2] = 16; data_cfg[2] = 9;
        sweep(cyc);
        chk("s2_collision", int'(p2), 9);
        chk("falha_collision", int'(falhaAdc), 0);
        wait_cfg[2] = 1; data_cfg[2] = 10;

        // Channel 6: 15 then 4.
        do_reset();
        data_cfg[6] = 15;
        sweep(cyc);
        chk("rea_first", int'(p6), 15);
        data_cfg[6] = 4;
        sweep(cyc);
`ifdef FILTRO_MEDIA_EN
        exp_rea = 10;
`else
        exp_rea = 4;
`endif
        chk("rea_second", int'(p6), exp_rea);

        // Reset while waiting on channel 3.
        wait_cfg[3] = 10;
        cyc = 0;
        while (!(m_ch == 3 && m_age >= 3 && m_age <= 16) && cyc < 400) begin step(); cyc++; end
        chk("reach_ch3_wait", int'(adcReq && adcCanal == 3'd3), 1);
        rst_n = 1'b0;
        step();
        chk("midreset_req", int'(adcReq), 0);
        chk("midreset_sc", int'(p0), 0);
        chk("midreset_rea", int'(p6), 0);
        rst_n = 1'b1;
        step();
        chk("restart_canal", int'(adcCanal), 0);
        chk("restart_req", int'(adcReq), 1);

        // Randomized phase: random waits, data, stray acknowledges, occasional reset.
        for (int i = 0; i < 7; i++) begin wait_cfg[i] = 0; data_cfg[i] = -1; end
        noise = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
